// File: rtl/bus_slot_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_slot_arbiter_if
// Request/acknowledge and slot-status bundle between the DRAM bus requesters
// and bus_slot_arbiter.
//   master : requester side (drives cpu/vid/snd/dma requests, snd_en)
//   slave  : arbiter side (drives slot position, grant, strobes, acks)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface bus_slot_arbiter_if;
    logic       cpu_req;
    logic       vid_req;
    logic       snd_req;
    logic       snd_en;
    logic       dma_req;
    logic [2:0] phase;
    logic       dma_slot;
    logic [4:0] gnt;
    logic [2:0] addr_src;
    logic       ram_cyc;
    logic       latch;
    logic [4:0] ack;
    logic       cpu_dtack_n;
    logic       ref_overrun;

    modport master (
        output cpu_req, vid_req, snd_req, snd_en, dma_req,
        input  phase, dma_slot, gnt, addr_src, ram_cyc, latch, ack,
               cpu_dtack_n, ref_overrun
    );

    modport slave (
        input  cpu_req, vid_req, snd_req, snd_en, dma_req,
        output phase, dma_slot, gnt, addr_src, ram_cyc, latch, ack,
               cpu_dtack_n, ref_overrun
    );
endinterface

// File: rtl/bus_slot_arbiter.sv
// ----------------------------------------------------------------------------
// bus_slot_arbiter
// Divides the shared DRAM bus into 8-clock slots, alternating CPU slot and
// DMA slot, and grants each slot to one of CPU, video, sound DMA, disk DMA or
// refresh. Drives the address-mux select, RAM cycle/latch strobes, per-
// requester ack pulses and the CPU DTACK.
// Ports:
//   clk32 : 32 MHz clock, rising edge
//   res   : asynchronous active-high reset
//   bus   : slave modport of bus_slot_arbiter_if (requests in, slot status,
//           grant, strobes, acks, cpu_dtack_n, ref_overrun out)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module bus_slot_arbiter #(
    parameter int unsigned REF_INTERVAL = 62,
    parameter int unsigned REF_MAXDEFER = 4
) (
    input  logic              clk32,
    input  logic              res,
    bus_slot_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        SRC_IDLE = 3'd0,
        SRC_CPU  = 3'd1,
        SRC_VID  = 3'd2,
        SRC_SND  = 3'd3,
        SRC_DMA  = 3'd4,
        SRC_REF  = 3'd5
    } src_e;

    localparam logic [4:0] G_CPU = 5'b00001;
    localparam logic [4:0] G_VID = 5'b00010;
    localparam logic [4:0] G_SND = 5'b00100;
    localparam logic [4:0] G_DMA = 5'b01000;
    localparam logic [4:0] G_REF = 5'b10000;

    localparam logic [7:0] REF_LAST = 8'(REF_INTERVAL - 1);
    localparam logic [3:0] AGE_LIM  = 4'(REF_MAXDEFER);

    logic [3:0] cnt_q, cnt_d;          // {dma_slot, phase}
    logic [4:0] gnt_q, gnt_d;
    src_e       src_q, src_d;
    logic [7:0] ref_cnt_q, ref_cnt_d;
    logic       ref_pend_q, ref_pend_d;
    logic [3:0] ref_age_q, ref_age_d;
    logic       dtack_n_q, dtack_n_d;
    logic       overrun_q, overrun_d;

    logic       slot_end;   // current clock is phase 7: next edge starts a slot
    logic       dma_start;  // next edge starts a DMA slot
    logic       ref_wrap;
    logic       pend_eff;   // pending including a wrap happening on this edge
    logic [3:0] age_inc;
    logic       aged;
    logic       ref_gnt;

    assign slot_end  = (cnt_q[2:0] == 3'd7);
    assign dma_start = slot_end & ~cnt_q[3];
    assign ref_wrap  = dma_start & (ref_cnt_q == REF_LAST);
    assign pend_eff  = ref_pend_q | ref_wrap;
    // Age is judged on the value it takes at this slot start, so a refresh
    // that went pending at slot N is aged at slot N+REF_MAXDEFER.
    assign age_inc   = (ref_pend_q && ref_age_q != 4'hF) ? ref_age_q + 4'd1 : ref_age_q;
    assign aged      = pend_eff & (age_inc >= AGE_LIM);

    always_comb begin
        cnt_d      = cnt_q + 4'd1;
        gnt_d      = gnt_q;
        src_d      = src_q;
        ref_gnt    = 1'b0;
        ref_cnt_d  = ref_cnt_q;
        ref_pend_d = ref_pend_q;
        ref_age_d  = ref_age_q;
        dtack_n_d  = dtack_n_q;
        overrun_d  = overrun_q | (ref_wrap & ref_pend_q);

        if (slot_end) begin
            gnt_d = '0;
            src_d = SRC_IDLE;
            if (cnt_q[3]) begin
                // Next slot is a CPU slot. A CPU cycle already acknowledged
                // (DTACK still low) must not be granted twice.
                if (bus.cpu_req && dtack_n_q) begin
                    gnt_d = G_CPU; src_d = SRC_CPU;
                end else if (bus.dma_req) begin
                    gnt_d = G_DMA; src_d = SRC_DMA;
                end
            end else begin
                if (aged) begin
                    gnt_d = G_REF; src_d = SRC_REF; ref_gnt = 1'b1;
                end else if (bus.vid_req) begin
                    gnt_d = G_VID; src_d = SRC_VID;
                end else if (pend_eff) begin
                    gnt_d = G_REF; src_d = SRC_REF; ref_gnt = 1'b1;
                end else if (bus.snd_req && bus.snd_en) begin
                    gnt_d = G_SND; src_d = SRC_SND;
                end else if (bus.dma_req) begin
                    gnt_d = G_DMA; src_d = SRC_DMA;
                end
            end
        end

        if (dma_start) begin
            ref_cnt_d  = ref_wrap ? 8'd0 : ref_cnt_q + 8'd1;
            ref_pend_d = pend_eff & ~ref_gnt;
            ref_age_d  = ref_gnt ? 4'd0 : age_inc;
        end

        if (gnt_q[0] && slot_end)
            dtack_n_d = 1'b0;
        else if (!bus.cpu_req)
            dtack_n_d = 1'b1;
    end

    always_ff @(posedge clk32 or posedge res) begin
        if (res) begin
            cnt_q      <= '0;
            gnt_q      <= '0;
            src_q      <= SRC_IDLE;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            ref_age_q  <= '0;
            dtack_n_q  <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            src_q      <= src_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            ref_age_q  <= ref_age_d;
            dtack_n_q  <= dtack_n_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.phase       = cnt_q[2:0];
    assign bus.dma_slot    = cnt_q[3];
    assign bus.gnt         = gnt_q;
    assign bus.addr_src    = src_q;
    assign bus.ram_cyc     = |gnt_q;
    assign bus.latch       = (|gnt_q) & (cnt_q[2:0] == 3'd6);
    assign bus.ack         = gnt_q & {5{slot_end}};
    assign bus.cpu_dtack_n = dtack_n_q;
    assign bus.ref_overrun = overrun_q;
endmodule

// File: tb/tb_bus_slot_arbiter.sv
`timescale 1ns/1ps
module tb_bus_slot_arbiter;
    logic clk32 = 1'b0;
    logic res   = 1'b1;
    logic res6  = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk32 = ~clk32;

    bus_slot_arbiter_if bif();
    bus_slot_arbiter_if bif6();

    bus_slot_arbiter u_dut (
        .clk32 (clk32),
        .res   (res),
        .bus   (bif.slave)
    );

    bus_slot_arbiter #(.REF_INTERVAL(2), .REF_MAXDEFER(15)) u_dut6 (
        .clk32 (clk32),
        .res   (res6),
        .bus   (bif6.slave)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk32);
    endtask

    task automatic clear_reqs();
        bif.cpu_req = 0; bif.vid_req = 0; bif.snd_req = 0;
        bif.snd_en  = 0; bif.dma_req = 0;
    endtask

    // Leaves the bench at a falling edge with the counter at 0 (k = 0).
    task automatic do_reset();
        @(negedge clk32);
        res = 1;
        clear_reqs();
        step(2);
        res = 0;
    endtask

    task automatic test_reset();
        @(negedge clk32);
        res = 1;
        clear_reqs();
        step(3);
        checks++; if (bif.gnt !== 5'b0) begin errors++; $display("FAIL rst_gnt: got %b want 00000", bif.gnt); end
        checks++; if (bif.addr_src !== 3'd0) begin errors++; $display("FAIL rst_addr_src: got %0d want 0", bif.addr_src); end
        checks++; if ({bif.ram_cyc, bif.latch} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b want 00", {bif.ram_cyc, bif.latch}); end
        checks++; if (bif.ack !== 5'b0) begin errors++; $display("FAIL rst_ack: got %b want 00000", bif.ack); end
        checks++; if (bif.cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL rst_dtack: got %b want 1", bif.cpu_dtack_n); end
        checks++; if (bif.ref_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", bif.ref_overrun); end
        checks++; if ({bif.dma_slot, bif.phase} !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", {bif.dma_slot, bif.phase}); end
    endtask

    task automatic test_cpu();
        do_reset();
        bif.cpu_req = 1;                       // k = 0
        step(8);                               // k = 8, DMA slot
        checks++; if (bif.gnt !== 5'b0 || bif.dma_slot !== 1'b1) begin errors++; $display("FAIL cpu_dma_slot: got gnt=%b slot=%b want 00000/1", bif.gnt, bif.dma_slot); end
        step(8);                               // k = 16, CPU grant starts
        checks++; if (bif.gnt !== 5'b00001 || bif.addr_src !== 3'd1) begin errors++; $display("FAIL cpu_gnt: got %b/%0d want 00001/1", bif.gnt, bif.addr_src); end
        checks++; if (bif.ram_cyc !== 1'b1) begin errors++; $display("FAIL cpu_ram_cyc: got %b want 1", bif.ram_cyc); end
        step(6);                               // phase 6
        checks++; if (bif.latch !== 1'b1 || bif.ack !== 5'b0) begin errors++; $display("FAIL cpu_latch: got latch=%b ack=%b want 1/00000", bif.latch, bif.ack); end
        step(1);                               // phase 7
        checks++; if (bif.ack !== 5'b00001 || bif.cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL cpu_ack: got ack=%b dtack=%b want 00001/1", bif.ack, bif.cpu_dtack_n); end
        step(1);                               // k = 24, clock 8 of grant
        checks++; if (bif.cpu_dtack_n !== 1'b0 || bif.gnt !== 5'b0 || bif.ack !== 5'b0) begin errors++; $display("FAIL cpu_dtack_low: got dtack=%b gnt=%b ack=%b want 0/00000/00000", bif.cpu_dtack_n, bif.gnt, bif.ack); end
        bif.cpu_req = 0;
        step(1);                               // k = 25
        checks++; if (bif.cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL cpu_dtack_rel: got %b want 1", bif.cpu_dtack_n); end
        step(1);
        bif.cpu_req = 1;                       // next bus cycle, k = 26
        step(6);                               // k = 32
        checks++; if (bif.gnt !== 5'b00001) begin errors++; $display("FAIL cpu_regrant: got %b want 00001", bif.gnt); end
        step(16);                              // k = 48, req held so DTACK still low
        checks++; if (bif.gnt !== 5'b0 || bif.cpu_dtack_n !== 1'b0) begin errors++; $display("FAIL cpu_no_dup: got gnt=%b dtack=%b want 00000/0", bif.gnt, bif.cpu_dtack_n); end
        bif.cpu_req = 0;
        step(1);
        checks++; if (bif.cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL cpu_dtack_rel2: got %b want 1", bif.cpu_dtack_n); end
    endtask

    task automatic test_dma_prio();
        logic [4:0] exp;
        do_reset();
        bif.vid_req = 1; bif.snd_req = 1; bif.snd_en = 1; bif.dma_req = 1;
        for (int i = 0; i < 8; i++) begin
            step(8);
            exp = (i % 2 == 0) ? 5'b00010 : 5'b01000;
            checks++; if (bif.gnt !== exp) begin errors++; $display("FAIL prio_slot%0d: got %b want %b", i, bif.gnt, exp); end
        end
        bif.vid_req = 0;                       // k = 64
        step(8);
        checks++; if (bif.gnt !== 5'b00100 || bif.addr_src !== 3'd3) begin errors++; $display("FAIL prio_snd: got %b/%0d want 00100/3", bif.gnt, bif.addr_src); end
        bif.snd_en = 0;
        step(7);
        checks++; if (bif.ack !== 5'b00100) begin errors++; $display("FAIL prio_snd_ack: got %b want 00100", bif.ack); end
        step(9);                               // k = 88, DMA slot
        checks++; if (bif.gnt !== 5'b01000 || bif.addr_src !== 3'd4) begin errors++; $display("FAIL prio_dma_in_dma_slot: got %b/%0d want 01000/4", bif.gnt, bif.addr_src); end
        clear_reqs();
    endtask

    task automatic test_refresh_idle();
        do_reset();
        bif.snd_req = 1; bif.snd_en = 0;
        step(968);                             // DMA slot 61
        checks++; if (bif.gnt !== 5'b0) begin errors++; $display("FAIL ref_slot61: got %b want 00000", bif.gnt); end
        step(16);                              // DMA slot 62
        checks++; if (bif.gnt !== 5'b10000 || bif.addr_src !== 3'd5) begin errors++; $display("FAIL ref_slot62: got %b/%0d want 10000/5", bif.gnt, bif.addr_src); end
        step(7);
        checks++; if (bif.ack !== 5'b10000) begin errors++; $display("FAIL ref_ack62: got %b want 10000", bif.ack); end
        step(9);                               // DMA slot 63
        checks++; if (bif.gnt !== 5'b0) begin errors++; $display("FAIL ref_slot63: got %b want 00000", bif.gnt); end
        step(976);                             // DMA slot 124
        checks++; if (bif.gnt !== 5'b10000) begin errors++; $display("FAIL ref_slot124: got %b want 10000", bif.gnt); end
        checks++; if (bif.ref_overrun !== 1'b0) begin errors++; $display("FAIL ref_idle_overrun: got %b want 0", bif.ref_overrun); end
        clear_reqs();
    endtask

    task automatic test_refresh_aged();
        do_reset();
        bif.vid_req = 1;
        step(984);                             // DMA slot 62: refresh pending, vid wins
        checks++; if (bif.gnt !== 5'b00010) begin errors++; $display("FAIL aged_slot62: got %b want 00010", bif.gnt); end
        step(48);                              // DMA slot 65
        checks++; if (bif.gnt !== 5'b00010) begin errors++; $display("FAIL aged_slot65: got %b want 00010", bif.gnt); end
        step(16);                              // DMA slot 66: aged refresh preempts
        checks++; if (bif.gnt !== 5'b10000) begin errors++; $display("FAIL aged_slot66: got %b want 10000", bif.gnt); end
        step(16);                              // DMA slot 67
        checks++; if (bif.gnt !== 5'b00010) begin errors++; $display("FAIL aged_slot67: got %b want 00010", bif.gnt); end
        checks++; if (bif.ref_overrun !== 1'b0) begin errors++; $display("FAIL aged_overrun: got %b want 0", bif.ref_overrun); end
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        int bad_ack;
        do_reset();
        bif.vid_req = 1;
        step(11);                              // phase 3 of vid slot
        checks++; if (bif.gnt !== 5'b00010 || bif.phase !== 3'd3) begin errors++; $display("FAIL mid_pre: got gnt=%b phase=%0d want 00010/3", bif.gnt, bif.phase); end
        res = 1;
        #1;
        checks++; if (bif.gnt !== 5'b0 || bif.ram_cyc !== 1'b0 || bif.ack !== 5'b0) begin errors++; $display("FAIL mid_clear: got gnt=%b ram_cyc=%b ack=%b want 00000/0/00000", bif.gnt, bif.ram_cyc, bif.ack); end
        bad_ack = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (bif.ack !== 5'b0) bad_ack++;
        end
        checks++; if (bad_ack != 0) begin errors++; $display("FAIL mid_no_ack: got %0d ack clocks want 0", bad_ack); end
        res = 0;
        checks++; if (bif.phase !== 3'd0 || bif.dma_slot !== 1'b0) begin errors++; $display("FAIL mid_release: got phase=%0d slot=%b want 0/0", bif.phase, bif.dma_slot); end
        step(8);
        checks++; if (bif.gnt !== 5'b00010 || bif.dma_slot !== 1'b1) begin errors++; $display("FAIL mid_resume: got gnt=%b slot=%b want 00010/1", bif.gnt, bif.dma_slot); end
        clear_reqs();
    endtask

    task automatic test_overrun();
        @(negedge clk32);
        res6 = 1;
        step(2);
        res6 = 0;                              // k = 0 for u_dut6
        step(40);                              // DMA slot 3: one wrap so far
        checks++; if (bif6.ref_overrun !== 1'b0 || bif6.gnt !== 5'b00010) begin errors++; $display("FAIL ovr_slot3: got ovr=%b gnt=%b want 0/00010", bif6.ref_overrun, bif6.gnt); end
        step(16);                              // DMA slot 4: second wrap while pending
        checks++; if (bif6.ref_overrun !== 1'b1 || bif6.gnt !== 5'b00010) begin errors++; $display("FAIL ovr_slot4: got ovr=%b gnt=%b want 1/00010", bif6.ref_overrun, bif6.gnt); end
        step(208);                             // DMA slot 17: age reaches 15
        checks++; if (bif6.gnt !== 5'b10000) begin errors++; $display("FAIL ovr_aged17: got %b want 10000", bif6.gnt); end
        step(64);
        checks++; if (bif6.ref_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bif6.ref_overrun); end
    endtask

    initial begin
        clear_reqs();
        bif6.cpu_req = 0; bif6.vid_req = 1; bif6.snd_req = 0;
        bif6.snd_en  = 0; bif6.dma_req = 0;
        test_reset();
        test_cpu();
        test_dma_prio();
        test_refresh_idle();
        test_refresh_aged();
        test_reset_mid();
        test_overrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
